// File: rtl/char_term_writer.sv
// Terminal-style character writer for the text frame buffer: consumes an ASCII
// stream, keeps a row/column cursor and emits single-cycle writes and clears.
module char_term_writer #(
  parameter int         COLS      = 80,
  parameter int         ROWS      = 25,
  parameter logic [7:0] FILL_CHAR = 8'h00
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        in_valid,
  input  logic [7:0]  in_char,
  output logic        in_ready,
  output logic [10:0] write_character_pos,
  output logic [7:0]  write_character,
  output logic        write_strobe,
  output logic [10:0] cursor_pos,
  output logic        busy
);

  localparam logic [10:0] NCOLS    = 11'(COLS);
  localparam logic [10:0] LAST_ROW = 11'(ROWS - 1);
  localparam logic [10:0] SCREEN   = 11'(ROWS * COLS);

  typedef enum logic [1:0] {IDLE, CLEAR_LINE, CLEAR_SCREEN} state_t;

  state_t      state;
  logic [10:0] row;
  logic [10:0] col;
  logic [10:0] clr_addr;
  logic [10:0] clr_limit;
  logic [10:0] here;
  logic [10:0] adv_row;
  logic [10:0] adv_base;
  logic        accept;

  assign in_ready   = (state == IDLE) && !RST;
  assign busy       = (state != IDLE);
  assign accept     = in_valid && in_ready;
  assign here       = row * NCOLS + col;
  assign cursor_pos = here;
  assign adv_row    = (row == LAST_ROW) ? 11'd0 : row + 11'd1;
  assign adv_base   = adv_row * NCOLS;

  // Clears stay in their state for one cycle after the last fill strobe so
  // that busy covers every write belonging to the clear.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state               <= CLEAR_SCREEN;
      row                 <= 11'd0;
      col                 <= 11'd0;
      clr_addr            <= 11'd0;
      clr_limit           <= SCREEN;
      write_strobe        <= 1'b0;
      write_character_pos <= 11'd0;
      write_character     <= 8'h00;
    end else begin
      write_strobe <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (in_char >= 8'h20 && in_char <= 8'h7E) begin
              write_strobe        <= 1'b1;
              write_character_pos <= here;
              write_character     <= in_char;
              if (col == NCOLS - 11'd1) begin
                col       <= 11'd0;
                row       <= adv_row;
                state     <= CLEAR_LINE;
                clr_addr  <= adv_base;
                clr_limit <= adv_base + NCOLS;
              end else begin
                col <= col + 11'd1;
              end
            end else begin
              case (in_char)
                8'h0D: col <= 11'd0;
                8'h0A: begin
                  col                 <= 11'd0;
                  row                 <= adv_row;
                  state               <= CLEAR_LINE;
                  write_strobe        <= 1'b1;
                  write_character_pos <= adv_base;
                  write_character     <= FILL_CHAR;
                  clr_addr            <= adv_base + 11'd1;
                  clr_limit           <= adv_base + NCOLS;
                end
                8'h08: begin
                  if (col != 11'd0) begin
                    col                 <= col - 11'd1;
                    write_strobe        <= 1'b1;
                    write_character_pos <= here - 11'd1;
                    write_character     <= FILL_CHAR;
                  end
                end
                8'h0C: begin
                  row                 <= 11'd0;
                  col                 <= 11'd0;
                  state               <= CLEAR_SCREEN;
                  write_strobe        <= 1'b1;
                  write_character_pos <= 11'd0;
                  write_character     <= FILL_CHAR;
                  clr_addr            <= 11'd1;
                  clr_limit           <= SCREEN;
                end
                default: ;
              endcase
            end
          end
        end
        CLEAR_LINE, CLEAR_SCREEN: begin
          if (clr_addr == clr_limit) begin
            state <= IDLE;
          end else begin
            write_strobe        <= 1'b1;
            write_character_pos <= clr_addr;
            write_character     <= FILL_CHAR;
            clr_addr            <= clr_addr + 11'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_char_term_writer.sv
// Directed self-checking bench for char_term_writer: reset clear, printing,
// wrap-with-line-clear, CR/LF/BS/FF handling and reset during a line clear.
module tb_char_term_writer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_char = 8'h00;
  logic        in_ready;
  logic [10:0] write_character_pos;
  logic [7:0]  write_character;
  logic        write_strobe;
  logic [10:0] cursor_pos;
  logic        busy;

  int     n_compared = 0;
  int     n_mismatched = 0;
  longint cycle = 0;

  int     q_pos[$];
  int     q_chr[$];
  int     q_busy[$];
  longint q_cyc[$];

  char_term_writer dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_char(in_char),
    .in_ready(in_ready), .write_character_pos(write_character_pos),
    .write_character(write_character), .write_strobe(write_strobe),
    .cursor_pos(cursor_pos), .busy(busy)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cycle <= cycle + 1;

  // Every visible strobe is logged with its address, data, busy flag and cycle.
  always @(negedge CLK) begin
    if (write_strobe === 1'b1) begin
      q_pos.push_back(int'(write_character_pos));
      q_chr.push_back(int'(write_character));
      q_busy.push_back(int'(busy));
      q_cyc.push_back(cycle);
    end
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic clearLog();
    q_pos.delete(); q_chr.delete(); q_busy.delete(); q_cyc.delete();
  endtask

  task automatic applyStimulus(input logic [7:0] c);
    int n = 0;
    @(negedge CLK);
    in_valid = 1'b1;
    in_char  = c;
    while (!in_ready && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    if (!in_ready) checkOutput("ready_timeout", 0, 1);
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    @(negedge CLK);
    while (busy && n < 2200) begin
      @(negedge CLK);
      n++;
    end
    checkOutput("idle_timeout", int'(busy), 0);
    repeat (2) @(negedge CLK);
  endtask

  // Counts log entries in a span that break the expected address/data pattern;
  // spans belonging to clears must also be back-to-back and flagged busy.
  task automatic checkSpan(input string tag, input int first, input int n,
                           input int pos0, input int chr, input bit is_clear);
    int bad = 0;
    if (q_pos.size() < first + n) begin
      checkOutput({tag, "_len"}, q_pos.size(), first + n);
      return;
    end
    for (int k = 0; k < n; k++) begin
      if (q_pos[first+k] != pos0 + k || q_chr[first+k] != chr) bad++;
      else if (is_clear && (q_busy[first+k] != 1 || q_cyc[first+k] != q_cyc[first] + k)) bad++;
    end
    checkOutput(tag, bad, 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset, then the power-up screen clear.
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checkOutput("rst_in_ready", int'(in_ready), 0);
    checkOutput("rst_strobe", int'(write_strobe), 0);
    checkOutput("rst_cursor", int'(cursor_pos), 0);
    checkOutput("rst_busy", int'(busy), 1);
    RST = 1'b0;
    clearLog();
    waitIdle();
    checkOutput("pwr_clear_count", q_pos.size(), 2000);
    checkSpan("pwr_clear_seq", 0, 2000, 0, 0, 1'b1);
    checkOutput("pwr_ready", int'(in_ready), 1);
    checkOutput("pwr_cursor", int'(cursor_pos), 0);

    // Printable byte: one-cycle latency write.
    applyStimulus(8'h41);
    @(negedge CLK);
    checkOutput("A_strobe", int'(write_strobe), 1);
    checkOutput("A_pos", int'(write_character_pos), 0);
    checkOutput("A_char", int'(write_character), 8'h41);
    checkOutput("A_cursor", int'(cursor_pos), 1);
    @(negedge CLK);
    checkOutput("A_strobe_once", int'(write_strobe), 0);

    applyStimulus(8'h0D);
    @(negedge CLK);
    checkOutput("cr_no_strobe", int'(write_strobe), 0);
    checkOutput("cr_cursor", int'(cursor_pos), 0);

    // A full row of 'x' wraps and clears row 1; the 81st byte waits.
    repeat (2) @(negedge CLK);
    clearLog();
    for (int i = 0; i < 81; i++) applyStimulus(8'h78);
    repeat (3) @(negedge CLK);
    checkOutput("wrap_count", q_pos.size(), 161);
    checkSpan("wrap_chars", 0, 80, 0, 8'h78, 1'b0);
    checkSpan("wrap_fill", 80, 80, 80, 0, 1'b1);
    if (q_pos.size() >= 161) begin
      checkOutput("wrap_fill_follows", int'(q_cyc[80] - q_cyc[79]), 1);
      checkOutput("held_after_clear", int'(q_cyc[160] > q_cyc[159]), 1);
      checkSpan("held_lands", 160, 1, 80, 8'h78, 1'b0);
    end
    checkOutput("wrap_cursor", int'(cursor_pos), 81);

    // Walk down to row 24, print to col 37, then CR and LF wrap to row 0.
    for (int i = 0; i < 23; i++) applyStimulus(8'h0A);
    for (int i = 0; i < 37; i++) applyStimulus(8'h61);
    @(negedge CLK);
    checkOutput("row24_cursor", int'(cursor_pos), 1957);
    applyStimulus(8'h0D);
    @(negedge CLK);
    checkOutput("cr37_no_strobe", int'(write_strobe), 0);
    checkOutput("cr37_cursor", int'(cursor_pos), 1920);
    clearLog();
    applyStimulus(8'h0A);
    waitIdle();
    checkOutput("lf_wrap_count", q_pos.size(), 80);
    checkSpan("lf_wrap_fill", 0, 80, 0, 0, 1'b1);
    checkOutput("lf_wrap_cursor", int'(cursor_pos), 0);

    // Backspace at column 0, then at column 5 of row 2.
    applyStimulus(8'h08);
    @(negedge CLK);
    checkOutput("bs0_no_strobe", int'(write_strobe), 0);
    checkOutput("bs0_cursor", int'(cursor_pos), 0);
    applyStimulus(8'h0A);
    applyStimulus(8'h0A);
    for (int i = 0; i < 5; i++) applyStimulus(8'h62);
    repeat (2) @(negedge CLK);
    checkOutput("bs_pre_cursor", int'(cursor_pos), 165);
    clearLog();
    applyStimulus(8'h08);
    @(negedge CLK);
    checkOutput("bs_strobe", int'(write_strobe), 1);
    checkOutput("bs_pos", int'(write_character_pos), 164);
    checkOutput("bs_char", int'(write_character), 0);
    checkOutput("bs_cursor", int'(cursor_pos), 164);
    repeat (3) @(negedge CLK);
    checkOutput("bs_single", q_pos.size(), 1);

    applyStimulus(8'h07);
    @(negedge CLK);
    checkOutput("ctl_no_strobe", int'(write_strobe), 0);
    checkOutput("ctl_cursor", int'(cursor_pos), 164);

    // Reset after 10 line-clear writes of row 3 restarts the screen clear.
    clearLog();
    applyStimulus(8'h0A);
    repeat (9) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(negedge CLK);
    checkOutput("rst_mid_ready", int'(in_ready), 0);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    waitIdle();
    checkOutput("rst_mid_count", q_pos.size(), 2010);
    checkSpan("rst_mid_line", 0, 10, 240, 0, 1'b1);
    checkSpan("rst_mid_screen", 10, 2000, 0, 0, 1'b1);
    checkOutput("rst_mid_cursor", int'(cursor_pos), 0);

    // Form feed mid-line.
    applyStimulus(8'h63);
    applyStimulus(8'h64);
    repeat (2) @(negedge CLK);
    checkOutput("ff_pre_cursor", int'(cursor_pos), 2);
    clearLog();
    applyStimulus(8'h0C);
    waitIdle();
    checkOutput("ff_count", q_pos.size(), 2000);
    checkSpan("ff_seq", 0, 2000, 0, 0, 1'b1);
    checkOutput("ff_cursor", int'(cursor_pos), 0);
    checkOutput("ff_ready", int'(in_ready), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
